// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared encodings and the forwarding-select helper for the hazard unit.
package hazard_stall_ctrl_pkg;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_e;
  typedef enum logic [1:0] {IDLE, WAIT, HALT} ctrl_state_e;
  function automatic fwd_sel_e fwd_sel(input logic [4:0] rs, input logic [4:0] rdm, input logic wm,
                                       input logic [4:0] rdw, input logic ww);
    return (wm && rdm != 5'd0 && rdm == rs) ? FWD_M : (ww && rdw != 5'd0 && rdw == rs) ? FWD_W : FWD_RF;
  endfunction
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks a pending data-memory access, freezes the pipe while it waits, halts on timeout.
module mem_wait_fsm
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MemReqM,
  input  logic mem_ready,
  output logic freeze,
  output logic rel,
  output logic mem_req,
  output logic mem_err
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  ctrl_state_e state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  logic err_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      mem_err  <= err_n;
    end
  end
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    err_n      = mem_err;
    freeze     = 1'b0;
    rel        = 1'b0;
    mem_req    = MemReqM && state != HALT;
    case (state)
      IDLE: if (MemReqM && !mem_ready) begin
        freeze     = 1'b1;
        state_n    = WAIT;
        wait_cnt_n = CW'(1);
      end
      WAIT: if (mem_ready) begin
        rel        = 1'b1;
        state_n    = IDLE;
        wait_cnt_n = '0;
      end else begin
        freeze = 1'b1;
        // a zero limit disables the timeout; the counter may then wrap harmlessly
        if (TIMEOUT_CYCLES != 0 && wait_cnt == CW'(TIMEOUT_CYCLES)) begin
          state_n = HALT;
          err_n   = 1'b1;
        end else wait_cnt_n = wait_cnt + CW'(1);
      end
      default: freeze = 1'b1;
    endcase
  end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: forwarding, load-use/branch hazards, memory-wait freeze and stall counting.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            Rs1E,
  input  logic [4:0]            Rs2E,
  input  logic [4:0]            RdE,
  input  logic [4:0]            RdM,
  input  logic [4:0]            RdW,
  input  logic [1:0]            ResultSrcE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  PCSrcE,
  input  logic                  MemReqM,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  EnEM,
  output logic                  ClrMW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  mem_err,
  output logic [DATA_WIDTH-1:0] stall_count
);
  logic freeze, rel, act, lu;
  mem_wait_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk(clk), .rst_n(rst_n), .MemReqM(MemReqM), .mem_ready(mem_ready),
    .freeze(freeze), .rel(rel), .mem_req(mem_req), .mem_err(mem_err)
  );
  assign lu        = ResultSrcE == RESULT_SRC_LOAD && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  // hazard rules only act when the pipe moves; a frozen E keeps PCSrcE alive until release
  assign act       = rel | ~freeze;
  assign StallF    = freeze | (act & lu & ~PCSrcE);
  assign StallD    = StallF;
  assign FlushD    = act & PCSrcE;
  assign FlushE    = act & (PCSrcE | lu);
  assign EnEM      = ~freeze;
  assign ClrMW     = freeze;
  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (StallF && !(&stall_count)) stall_count <= stall_count + DATA_WIDTH'(1);
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed + random stimulus, reference model feeds a scoreboard checked by a monitor.
module tb_hazard_stall_ctrl;
  localparam int DW = 4;
  localparam int TO = 4;
  typedef struct packed {
    logic [4:0] r1d, r2d, r1e, r2e, rde, rdm, rdw;
    logic [1:0] rs;
    logic rwm, rww, pc, mrq, mrdy, rn;
  } stim_t;
  typedef struct packed {
    logic mreq, sf, sd, fd, fe, enem, clrmw;
    logic [1:0] fa, fb;
    logic err;
    logic [DW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0, RdM = '0, RdW = '0;
  logic [1:0] ResultSrcE = '0;
  logic RegWriteM = 0, RegWriteW = 0, PCSrcE = 0, MemReqM = 0, mem_ready = 0;
  logic mem_req, StallF, StallD, FlushD, FlushE, EnEM, ClrMW, mem_err;
  logic [1:0] ForwardAE, ForwardBE;
  logic [DW-1:0] stall_count;

  hazard_stall_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .mem_ready(mem_ready),
    .mem_req(mem_req), .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .EnEM(EnEM), .ClrMW(ClrMW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0, bad = 0;
  bit halted = 0, err = 0;
  int waited = 0, cnt = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, x, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("mem_req", mem_req, e.mreq);
      chk("StallF", StallF, e.sf);
      chk("StallD", StallD, e.sd);
      chk("FlushD", FlushD, e.fd);
      chk("FlushE", FlushE, e.fe);
      chk("EnEM", EnEM, e.enem);
      chk("ClrMW", ClrMW, e.clrmw);
      chk("ForwardAE", ForwardAE, e.fa);
      chk("ForwardBE", ForwardBE, e.fb);
      chk("mem_err", mem_err, e.err);
      chk("stall_count", stall_count, e.cnt);
    end
  end

  // youngest writer of the register wins; x0 is never forwarded
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    logic [4:0] rd[2];
    logic we[2];
    rd[0] = s.rdm; rd[1] = s.rdw;
    we[0] = s.rwm; we[1] = s.rww;
    for (int i = 0; i < 2; i++)
      if (we[i] && rs != 0 && rd[i] == rs) return i == 0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.rn = 1'b1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit busy, lu, go;
    @(posedge clk);
    #1;
    Rs1D = s.r1d; Rs2D = s.r2d; Rs1E = s.r1e; Rs2E = s.r2e;
    RdE = s.rde; RdM = s.rdm; RdW = s.rdw; ResultSrcE = s.rs;
    RegWriteM = s.rwm; RegWriteW = s.rww; PCSrcE = s.pc;
    MemReqM = s.mrq; mem_ready = s.mrdy; rst_n = s.rn;
    if (!s.rn) begin halted = 0; waited = 0; err = 0; cnt = 0; end
    busy = halted || ((waited > 0 || s.mrq) && !s.mrdy);
    go = !busy;
    lu = s.rs == 2'b01 && s.rde != 0 && (s.rde == s.r1d || s.rde == s.r2d);
    e.mreq = s.mrq && !halted;
    e.sf = busy || (go && lu && !s.pc);
    e.sd = e.sf;
    e.fd = go && s.pc;
    e.fe = go && (s.pc || lu);
    e.enem = !busy;
    e.clrmw = busy;
    e.fa = ref_fwd(s.r1e, s);
    e.fb = ref_fwd(s.r2e, s);
    e.err = err;
    e.cnt = DW'(cnt);
    q.push_back(e);
    if (s.rn) begin
      if (e.sf && cnt < (1 << DW) - 1) cnt++;
      if (!halted) begin
        if (!busy) waited = 0;
        else if (TO != 0 && waited >= TO) begin halted = 1; err = 1; end
        else waited++;
      end
    end
  endtask

  initial begin
    stim_t s;
    s = base(); s.rn = 0;
    step(s); step(s);
    s.rn = 1; step(s);
    s = base(); s.rde = 5; s.rs = 2'b01; s.r1d = 5; step(s);
    s.rde = 0; step(s);
    s.rde = 5; s.r1d = 0; s.r2d = 5; step(s);
    s.pc = 1; step(s);
    s = base(); s.rdm = 7; s.rdw = 7; s.rwm = 1; s.rww = 1; s.r1e = 7; s.r2e = 7; step(s);
    s.rwm = 0; step(s);
    s.r1e = 0; step(s);
    s = base(); s.mrq = 1;
    repeat (4) step(s);
    s.mrdy = 1; step(s);
    s.mrq = 0; step(s);
    s.mrq = 1; step(s);
    s.mrdy = 0;
    repeat (8) step(s);
    s.rn = 0; s.mrq = 0; step(s);
    s.rn = 1; step(s);
    s = base(); s.mrq = 1; s.pc = 1;
    repeat (3) step(s);
    s.mrdy = 1; step(s);
    s = base(); step(s);
    s.mrq = 1;
    repeat (2) step(s);
    s.mrq = 0; s.rn = 0; step(s);
    s.rn = 1; step(s);
    for (int i = 0; i < 600; i++) begin
      s.r1d = 5'($urandom_range(0, 7)); s.r2d = 5'($urandom_range(0, 7));
      s.r1e = 5'($urandom_range(0, 7)); s.r2e = 5'($urandom_range(0, 7));
      s.rde = 5'($urandom_range(0, 7)); s.rdm = 5'($urandom_range(0, 7));
      s.rdw = 5'($urandom_range(0, 7)); s.rs = 2'($urandom_range(0, 3));
      s.rwm = 1'($urandom); s.rww = 1'($urandom);
      s.pc = $urandom_range(0, 3) == 0;
      s.mrq = $urandom_range(0, 2) == 0;
      s.mrdy = 1'($urandom);
      s.rn = $urandom_range(0, 49) != 0;
      step(s);
    end
    repeat (2) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
